hazard_control_unit: RTL and testbench

Pipeline sequencing controller for the 5-stage core. It generates per-stage enable, flush and bubble controls, covering three cases:
- load-use stalls that operand forwarding cannot cover;
- multi-cycle memory-stage operations;
- taken-branch flushes.

It sits beside the forwarding logic, consumes decode/execute/memory stage register tags, and drives the PC and pipeline-register control pins.

---
 rtl/hazard_control_unit_pkg.sv | 27 ++
 rtl/hazard_control_unit_if.sv | 54 +++++
 rtl/hazard_control_unit_load_use_detect.sv | 43 ++++
 rtl/hazard_control_unit.sv | 152 +++++++++++++++
 tb/tb_hazard_control_unit.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// hcu_pkg -- shared types and constants for the hazard control unit.
//
// Contents:
//   hcu_state_t    : sequencing FSM state (RUN / WAIT)
//   REG_ADDR_W_DEF : default register-index width
//   STALL_CNT_W    : width of the stall-cycle statistics counter
//   CNT_W          : width of the memory-wait down-counter
//   sat_inc()      : saturating increment for the statistics counter
// ---------------------------------------------------------------------------
package hcu_pkg;

   localparam int REG_ADDR_W_DEF = 3;
   localparam int STALL_CNT_W    = 16;
   localparam int CNT_W          = 4;

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } hcu_state_t;

   // Holds at all-ones instead of wrapping back to zero.
   function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
      return (&v) ? v : v + STALL_CNT_W'(1);
   endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_control_unit_if -- bundle between the pipeline and the hazard unit.
//
// Pipeline -> unit : decode source tags/uses, execute destination/writeback/
//                    load/branch flags, MEM long-op flag, statistics clear.
// Unit -> pipeline : stage enables, IF/ID flush, ID/EX and MEM/WB bubbles,
//                    busy flag, stall-cycle counter.
//
// Modports:
//   slave  : the hazard control unit itself
//   master : the pipeline (or testbench) that feeds it
// ---------------------------------------------------------------------------
interface hazard_control_unit_if
   import hcu_pkg::*;
   #(parameter int REG_ADDR_W = REG_ADDR_W_DEF);

   // decode / execute / memory stage information
   logic [REG_ADDR_W-1:0]  rsrc1_id;
   logic [REG_ADDR_W-1:0]  rsrc2_id;
   logic                   use_src1_id;
   logic                   use_src2_id;
   logic [REG_ADDR_W-1:0]  rdst_ex;
   logic                   wb_ex;
   logic                   mem_read_ex;
   logic                   branch_taken_ex;
   logic                   mem_long_mem;
   logic                   stat_clr;

   // pipeline control outputs
   logic                   pc_en;
   logic                   if_id_en;
   logic                   id_ex_en;
   logic                   ex_mem_en;
   logic                   if_id_flush;
   logic                   id_ex_bubble;
   logic                   mem_wb_bubble;
   logic                   busy;
   logic [STALL_CNT_W-1:0] stall_count;

   modport slave (
      input  rsrc1_id, rsrc2_id, use_src1_id, use_src2_id, rdst_ex,
             wb_ex, mem_read_ex, branch_taken_ex, mem_long_mem, stat_clr,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush,
             id_ex_bubble, mem_wb_bubble, busy, stall_count
   );

   modport master (
      output rsrc1_id, rsrc2_id, use_src1_id, use_src2_id, rdst_ex,
             wb_ex, mem_read_ex, branch_taken_ex, mem_long_mem, stat_clr,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush,
             id_ex_bubble, mem_wb_bubble, busy, stall_count
   );

endinterface

// File: rtl/hazard_control_unit_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect -- combinational load-use hazard comparator.
//
// Flags the case forwarding cannot cover: the instruction in execute is a
// load (data only exists after MEM) that writes a register the decode
// instruction actually reads.
//
// Ports:
//   rsrc1_id, rsrc2_id       : decode source register tags
//   use_src1_id, use_src2_id : decode instruction really reads that source
//   rdst_ex                  : execute destination tag
//   wb_ex, mem_read_ex       : execute writes back / is a load
//   hazard                   : one-cycle stall required
// ---------------------------------------------------------------------------
module load_use_detect
   import hcu_pkg::*;
   #(parameter int REG_ADDR_W = REG_ADDR_W_DEF)
   (
      input  logic [REG_ADDR_W-1:0] rsrc1_id,
      input  logic [REG_ADDR_W-1:0] rsrc2_id,
      input  logic                  use_src1_id,
      input  logic                  use_src2_id,
      input  logic [REG_ADDR_W-1:0] rdst_ex,
      input  logic                  wb_ex,
      input  logic                  mem_read_ex,
      output logic                  hazard
   );

   logic [REG_ADDR_W-1:0] src_tag [2];
   logic [1:0]            src_use;
   logic [1:0]            src_hit;

   assign src_tag[0] = rsrc1_id;
   assign src_tag[1] = rsrc2_id;
   assign src_use    = {use_src2_id, use_src1_id};

   for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_use[gi] && (src_tag[gi] == rdst_ex);
   end

   assign hazard = mem_read_ex && wb_ex && (|src_hit);

endmodule

// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit -- pipeline sequencing controller for the 5-stage core.
//
// Produces per-stage enables plus flush/bubble controls for three cases, in
// priority order:
//   freeze   : long memory op holds MEM; everything upstream of MEM/WB stops
//   branch   : taken branch in EX kills the IF/ID and ID/EX instructions
//   load-use : decode waits one cycle behind a load it depends on
// All controls are combinational from state, counter and current inputs.
//
// Ports:
//   clk   : core clock
//   rst_n : asynchronous active-low reset
//   hcu   : hazard_control_unit_if.slave (tags in, controls/statistics out)
//
// Parameters:
//   REG_ADDR_W : register-index width
//   MEM_WAIT   : freeze cycles for a long memory op (1..15)
// ---------------------------------------------------------------------------
module hazard_control_unit
   import hcu_pkg::*;
   #(
      parameter int REG_ADDR_W = REG_ADDR_W_DEF,
      parameter int MEM_WAIT   = 1
   )
   (
      input  logic                  clk,
      input  logic                  rst_n,
      hazard_control_unit_if.slave  hcu
   );

   // The entering RUN cycle is itself a freeze cycle, so the counter only
   // needs to cover the remaining MEM_WAIT-1 of them.
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_WAIT - 1);

   hcu_state_t             state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic [STALL_CNT_W-1:0] stall_count_reg, stall_count_next;

   logic hazard;
   logic freeze;
   logic stall_cycle;

   logic pc_en, if_id_en, id_ex_en, ex_mem_en;
   logic if_id_flush, id_ex_bubble, mem_wb_bubble, busy;

   load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
      .rsrc1_id    (hcu.rsrc1_id),
      .rsrc2_id    (hcu.rsrc2_id),
      .use_src1_id (hcu.use_src1_id),
      .use_src2_id (hcu.use_src2_id),
      .rdst_ex     (hcu.rdst_ex),
      .wb_ex       (hcu.wb_ex),
      .mem_read_ex (hcu.mem_read_ex),
      .hazard      (hazard)
   );

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= RUN;
         cnt_reg         <= '0;
         stall_count_reg <= '0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         stall_count_reg <= stall_count_next;
      end
   end

   // ------------------------------------------------------------------
   // Next state and output decode
   // ------------------------------------------------------------------
   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      freeze           = 1'b0;
      stall_cycle      = 1'b0;
      pc_en            = 1'b1;
      if_id_en         = 1'b1;
      id_ex_en         = 1'b1;
      ex_mem_en        = 1'b1;
      if_id_flush      = 1'b0;
      id_ex_bubble     = 1'b0;
      mem_wb_bubble    = 1'b0;
      busy             = 1'b0;
      stall_count_next = stall_count_reg;

      case (state_reg)
         RUN: begin
            if (hcu.mem_long_mem) begin
               freeze     = 1'b1;
               state_next = WAIT;
               cnt_next   = WAIT_LOAD;
            end
         end
         WAIT: begin
            // mem_long_mem is deliberately ignored here: the op still sitting
            // in MEM must not re-arm the wait. cnt == 0 is the release cycle.
            if (cnt_reg != '0) begin
               freeze   = 1'b1;
               cnt_next = cnt_reg - CNT_W'(1);
            end else begin
               state_next = RUN;
            end
         end
         default: begin
            state_next = RUN;
            cnt_next   = '0;
         end
      endcase

      if (freeze) begin
         pc_en         = 1'b0;
         if_id_en      = 1'b0;
         id_ex_en      = 1'b0;
         ex_mem_en     = 1'b0;
         mem_wb_bubble = 1'b1;
         busy          = 1'b1;
         stall_cycle   = 1'b1;
      end else if (hcu.branch_taken_ex) begin
         // The dependent instruction of any coincident load-use hazard is the
         // one being killed, so the hazard is not acted on.
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (hazard) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_bubble = 1'b1;
         stall_cycle  = 1'b1;
      end

      if (hcu.stat_clr) begin
         stall_count_next = '0;
      end else if (stall_cycle) begin
         stall_count_next = sat_inc(stall_count_reg);
      end
   end

   assign hcu.pc_en         = pc_en;
   assign hcu.if_id_en      = if_id_en;
   assign hcu.id_ex_en      = id_ex_en;
   assign hcu.ex_mem_en     = ex_mem_en;
   assign hcu.if_id_flush   = if_id_flush;
   assign hcu.id_ex_bubble  = id_ex_bubble;
   assign hcu.mem_wb_bubble = mem_wb_bubble;
   assign hcu.busy          = busy;
   assign hcu.stall_count   = stall_count_reg;

endmodule

// File: tb/tb_hazard_control_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_control_unit -- self-checking bench for hazard_control_unit.
//
// Two instances (MEM_WAIT = 3 and MEM_WAIT = 2) share one stimulus stream.
// Output bytes are packed as
//   {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble,
//    mem_wb_bubble, busy}
// so: normal = F0, load-use = 34, branch = FC, freeze = 03.
// ---------------------------------------------------------------------------
module tb_hazard_control_unit;

   localparam logic [7:0] O_NORM = 8'hF0;
   localparam logic [7:0] O_LU   = 8'h34;
   localparam logic [7:0] O_BR   = 8'hFC;
   localparam logic [7:0] O_FRZ  = 8'h03;

   logic       clk;
   logic       rst_n;
   logic [2:0] rsrc1_id, rsrc2_id, rdst_ex;
   logic       use_src1_id, use_src2_id, wb_ex, mem_read_ex;
   logic       branch_taken_ex, mem_long_mem, stat_clr;

   int n_err;
   int n_checks;

   hazard_control_unit_if #(.REG_ADDR_W(3)) hif3 ();
   hazard_control_unit_if #(.REG_ADDR_W(3)) hif2 ();

   assign hif3.rsrc1_id        = rsrc1_id;
   assign hif3.rsrc2_id        = rsrc2_id;
   assign hif3.use_src1_id     = use_src1_id;
   assign hif3.use_src2_id     = use_src2_id;
   assign hif3.rdst_ex         = rdst_ex;
   assign hif3.wb_ex           = wb_ex;
   assign hif3.mem_read_ex     = mem_read_ex;
   assign hif3.branch_taken_ex = branch_taken_ex;
   assign hif3.mem_long_mem    = mem_long_mem;
   assign hif3.stat_clr        = stat_clr;

   assign hif2.rsrc1_id        = rsrc1_id;
   assign hif2.rsrc2_id        = rsrc2_id;
   assign hif2.use_src1_id     = use_src1_id;
   assign hif2.use_src2_id     = use_src2_id;
   assign hif2.rdst_ex         = rdst_ex;
   assign hif2.wb_ex           = wb_ex;
   assign hif2.mem_read_ex     = mem_read_ex;
   assign hif2.branch_taken_ex = branch_taken_ex;
   assign hif2.mem_long_mem    = mem_long_mem;
   assign hif2.stat_clr        = stat_clr;

   hazard_control_unit #(.REG_ADDR_W(3), .MEM_WAIT(3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .hcu   (hif3.slave)
   );

   hazard_control_unit #(.REG_ADDR_W(3), .MEM_WAIT(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .hcu   (hif2.slave)
   );

   logic [7:0] out3, out2;
   assign out3 = {hif3.pc_en, hif3.if_id_en, hif3.id_ex_en, hif3.ex_mem_en,
                  hif3.if_id_flush, hif3.id_ex_bubble, hif3.mem_wb_bubble, hif3.busy};
   assign out2 = {hif2.pc_en, hif2.if_id_en, hif2.id_ex_en, hif2.ex_mem_en,
                  hif2.if_id_flush, hif2.id_ex_bubble, hif2.mem_wb_bubble, hif2.busy};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ------------------------------------------------------------------
   // Reference model: ph = cycles of the current long op still to come in
   // MEM (including its release cycle); 0 means a new op may start.
   // ------------------------------------------------------------------
   int mw   [2];
   int ph   [2];
   int scnt [2];

   function automatic logic [7:0] model_out(input int p);
      logic haz;
      haz = mem_read_ex && wb_ex &&
            ((use_src1_id && rsrc1_id == rdst_ex) || (use_src2_id && rsrc2_id == rdst_ex));
      if (p > 1 || (p == 0 && mem_long_mem)) return O_FRZ;
      if (branch_taken_ex)                   return O_BR;
      if (haz)                               return O_LU;
      return O_NORM;
   endfunction

   task automatic model_update();
      logic [7:0] o;
      for (int i = 0; i < 2; i++) begin
         o = model_out(ph[i]);
         if (stat_clr)                                    scnt[i] = 0;
         else if ((o == O_FRZ || o == O_LU) && scnt[i] < 65535) scnt[i] = scnt[i] + 1;
         if (ph[i] == 0 && mem_long_mem) ph[i] = mw[i];
         else if (ph[i] > 0)             ph[i] = ph[i] - 1;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         ph[i]   = 0;
         scnt[i] = 0;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                         input logic u1, input logic u2, input logic wb, input logic mr,
                         input logic br, input logic ml, input logic sc);
      rsrc1_id = rs1; rsrc2_id = rs2; rdst_ex = rd;
      use_src1_id = u1; use_src2_id = u2; wb_ex = wb; mem_read_ex = mr;
      branch_taken_ex = br; mem_long_mem = ml; stat_clr = sc;
   endtask

   task automatic idle();
      set_in(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // One clock: compare both instances with the model mid-cycle, then
   // advance the model at the edge. Returns the sampled output bytes.
   task automatic step(input string tag, output logic [7:0] o3, output logic [7:0] o2);
      @(negedge clk);
      o3 = out3;
      o2 = out2;
      check($sformatf("%s_out_mw3", tag), {24'd0, out3}, {24'd0, model_out(ph[0])});
      check($sformatf("%s_out_mw2", tag), {24'd0, out2}, {24'd0, model_out(ph[1])});
      check($sformatf("%s_cnt_mw3", tag), {16'd0, hif3.stall_count}, scnt[0]);
      check($sformatf("%s_cnt_mw2", tag), {16'd0, hif2.stall_count}, scnt[1]);
      $display("%s: in={rs1=%0d rs2=%0d rd=%0d u=%b%b wb=%b mr=%b br=%b ml=%b clr=%b} out3=%h out2=%h cnt3=%0d cnt2=%0d",
               tag, rsrc1_id, rsrc2_id, rdst_ex, use_src1_id, use_src2_id, wb_ex,
               mem_read_ex, branch_taken_ex, mem_long_mem, stat_clr, out3, out2,
               hif3.stall_count, hif2.stall_count);
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      model_reset();
      #3;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [2:0] rs1, rs2, rd;
      logic       u1, u2, wb, mr, br;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [12];

   initial begin
      logic [7:0] o3, o2;
      logic [7:0] seq3 [4];
      logic [7:0] seq2 [4];

      n_err    = 0;
      n_checks = 0;
      mw[0]    = 3;
      mw[1]    = 2;

      //            rs1   rs2   rd    u1    u2    wb    mr    br    expected
      vecs[0]  = '{3'd1, 3'd3, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, O_LU};
      vecs[1]  = '{3'd1, 3'd3, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, O_NORM};
      vecs[2]  = '{3'd1, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_NORM};
      vecs[3]  = '{3'd3, 3'd5, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, O_LU};
      vecs[4]  = '{3'd3, 3'd5, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, O_NORM};
      vecs[5]  = '{3'd2, 3'd4, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, O_NORM};
      vecs[6]  = '{3'd1, 3'd3, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_NORM};
      vecs[7]  = '{3'd1, 3'd3, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, O_BR};
      vecs[8]  = '{3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_BR};
      vecs[9]  = '{3'd7, 3'd7, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, O_LU};
      vecs[10] = '{3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, O_LU};
      vecs[11] = '{3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM};

      rst_n = 1'b0;
      idle();
      do_reset();

      // Reset state
      @(negedge clk);
      check("reset_out", {24'd0, out3}, {24'd0, O_NORM});
      check("reset_cnt", {16'd0, hif3.stall_count}, 32'd0);
      @(posedge clk);
      #1;

      // Load then dependent add: one stall, next cycle clean
      set_in(3'd1, 3'd3, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("lu_stall", o3, o2);
      check("lu_stall_out", {24'd0, o3}, {24'd0, O_LU});
      set_in(3'd1, 3'd3, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step("lu_after", o3, o2);
      check("lu_after_out", {24'd0, o3}, {24'd0, O_NORM});
      check("lu_cnt", {16'd0, hif3.stall_count}, 32'd1);

      // Single-cycle decode table
      do_reset();
      for (int i = 0; i < 12; i++) begin
         set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].u1, vecs[i].u2,
                vecs[i].wb, vecs[i].mr, vecs[i].br, 1'b0, 1'b0);
         step($sformatf("vec%0d", i), o3, o2);
         check($sformatf("vec%0d_mw3", i), {24'd0, o3}, {24'd0, vecs[i].exp});
         check($sformatf("vec%0d_mw2", i), {24'd0, o2}, {24'd0, vecs[i].exp});
      end

      // Long op held with its instruction for MEM_WAIT+1 cycles (MEM_WAIT=3)
      do_reset();
      seq3 = '{O_FRZ, O_FRZ, O_FRZ, O_NORM};
      set_in(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step($sformatf("long%0d", i), o3, o2);
         check($sformatf("long%0d_mw3", i), {24'd0, o3}, {24'd0, seq3[i]});
      end
      idle();
      step("long_after", o3, o2);
      check("long_after_mw3", {24'd0, o3}, {24'd0, O_NORM});
      check("long_cnt_mw3", {16'd0, hif3.stall_count}, 32'd3);

      // Branch held in EX during a freeze flushes in the release cycle
      do_reset();
      seq3 = '{O_FRZ, O_FRZ, O_FRZ, O_BR};
      seq2 = '{O_FRZ, O_FRZ, O_BR, O_BR};
      for (int i = 0; i < 4; i++) begin
         set_in(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (i == 0), 1'b0);
         step($sformatf("brfrz%0d", i), o3, o2);
         check($sformatf("brfrz%0d_mw3", i), {24'd0, o3}, {24'd0, seq3[i]});
         check($sformatf("brfrz%0d_mw2", i), {24'd0, o2}, {24'd0, seq2[i]});
      end
      idle();

      // Reset asserted while in WAIT with cnt = 2 (MEM_WAIT=3 after entry)
      do_reset();
      mem_long_mem = 1'b1;
      step("rst_wait_entry", o3, o2);
      mem_long_mem = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_wait_out", {24'd0, out3}, {24'd0, O_NORM});
      check("rst_wait_busy", {31'd0, hif3.busy}, 32'd0);
      check("rst_wait_cnt", {16'd0, hif3.stall_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step("rst_wait_after", o3, o2);
      check("rst_wait_after_mw3", {24'd0, o3}, {24'd0, O_NORM});

      // Saturation: hold a load-use hazard past 65535 stall cycles
      do_reset();
      set_in(3'd1, 3'd3, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (65540) @(posedge clk);
      scnt[0] = 65535;
      scnt[1] = 65535;
      #1;
      step("sat_hold", o3, o2);
      check("sat_cnt_mw3", {16'd0, hif3.stall_count}, 32'h0000FFFF);
      stat_clr = 1'b1;
      step("sat_clr", o3, o2);
      stat_clr = 1'b0;
      check("clr_cnt_mw3", {16'd0, hif3.stall_count}, 32'd0);
      check("clr_cnt_mw2", {16'd0, hif2.stall_count}, 32'd0);

      // Randomised traffic against the model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         set_in(3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 39) == 0));
         step($sformatf("rnd%0d", i), o3, o2);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
